johnson_seq_ctrl: RTL and testbench
===================================

JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the Johnson register width (legal range 2..16).
REQ-002 Parameter CNT_W, default 8, SHALL set the step-count width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-005 clr  input  1  SHALL be the synchronous clear: Q to 0, FSM to IDLE.
REQ-006 start  input  1  SHALL request a run of count_len steps (level sampled per cycle).
REQ-007 stop  input  1  SHALL abort a run in progress.
REQ-008 dir  input  1  SHALL select step direction: 0 forward, 1 reverse.
REQ-009 count_len  input  CNT_W  SHALL give the number of steps for the run.
REQ-010 Q  output  WIDTH  SHALL be the Johnson counter state.
REQ-011 phase_idx  output  $clog2(2*WIDTH)  SHALL be the decoded phase position of Q.
REQ-012 busy  output  1  SHALL be high while in RUN.
REQ-013 done  output  1  SHALL pulse high for exactly one cycle when a run completes.
REQ-014 err  output  1  SHALL be the sticky illegal-state flag (see Configuration).

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE; all outputs registered except phase_idx.
REQ-016 Forward step SHALL be Q <= {Q[WIDTH-2:0], ~Q[WIDTH-1]}; reverse step SHALL be Q <= {~Q[0], Q[WIDTH-1:1]}.
REQ-017 Forward sequence for WIDTH=4 SHALL be 0000,0001,0011,0111,1111,1110,1100,1000, wrapping 1000->0000; reverse SHALL wrap 0000->1000.
REQ-018 phase_idx SHALL be popcount(Q) when Q[0]=1 or Q=0, else 2*WIDTH-popcount(Q) (0..7 for WIDTH=4).
REQ-019 IDLE with start=1 and count_len!=0 SHALL load remaining<=count_len and enter RUN next edge; Q does not step on that edge.
REQ-020 IDLE with start=1 and count_len=0 SHALL enter DONE directly (done pulse, no step).
REQ-021 RUN SHALL step Q once per cycle in the direction given by dir in that cycle and decrement remaining.
REQ-022 RUN with remaining=1 SHALL take the final step and enter DONE; a run of N steps SHALL hold busy for exactly N cycles.
REQ-023 stop=1 in RUN SHALL return to IDLE next edge without stepping and without a done pulse; stop outside RUN SHALL be ignored.
REQ-024 start in RUN or DONE SHALL be ignored; DONE SHALL always return to IDLE after one cycle.
REQ-025 Priority SHALL be reset > clr > stop > step/start.
REQ-026 clr SHALL force Q=0, FSM=IDLE, remaining=0, busy=0, done=0 next edge; err is unaffected.
REQ-027 Q SHALL hold its value in IDLE and DONE.

Reset
REQ-028 reset=0 SHALL immediately force Q=0, FSM=IDLE, remaining=0, busy=0, done=0, err=0, regardless of clk.
REQ-029 Reset asserted mid-run SHALL abort the run with no done pulse; after release the block SHALL idle until a new start.

Configuration
REQ-030 Macro JC_ILLEGAL_RECOVER_EN defined: any Q outside the 2*WIDTH legal Johnson codes SHALL be replaced by 0 on the next edge, and err SHALL be set and held until reset.
REQ-031 Recovery SHALL take precedence over stepping; a run in progress continues from Q=0 with remaining decremented as normal.
REQ-032 Macro undefined: no illegal-state detection; err SHALL be tied to 0.

Verification
REQ-033 Reset release, start=1, count_len=3, dir=0 -> Q 0001,0011,0111; busy high for 3 cycles; done pulses the cycle after Q=0111.
REQ-034 From Q=0000, count_len=9, dir=0 -> Q passes 1000 then wraps to 0000, ends at 0001; phase_idx ends at 1.
REQ-035 From Q=0000, count_len=2, dir=1 -> Q 1000, 1100; phase_idx 7, 6.
REQ-036 count_len=10, stop=1 after 4 steps -> Q frozen at 1111, busy low next cycle, no done pulse; start with count_len=0 in IDLE -> single done pulse, Q unchanged.
REQ-037 reset=0 asserted asynchronously mid-run -> Q=0000, busy=0, done=0 immediately, without waiting for a clk edge.
REQ-038 With JC_ILLEGAL_RECOVER_EN defined, force Q=0101 -> Q=0000 next edge, err=1 sticky until reset; without the macro, err stays 0.

Source files
------------

// File: rtl/johnson_seq_ctrl.sv
// Johnson counter sequencer: runs count_len forward/reverse steps under an IDLE/RUN/DONE FSM.
// Optional illegal-code recovery and sticky err flag enabled by defining JC_ILLEGAL_RECOVER_EN.
module johnson_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned PW   = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [CNT_W-1:0] count_len,
    output logic [WIDTH-1:0] Q,
    output logic [PW-1:0]    phase_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] q_fwd;
    logic [WIDTH-1:0] q_rev;

    assign q_fwd = {Q[WIDTH-2:0], ~Q[WIDTH-1]};
    assign q_rev = {~Q[0], Q[WIDTH-1:1]};

`ifdef JC_ILLEGAL_RECOVER_EN
    logic             err_q;
    logic             legal;
    logic [WIDTH-1:0] q_inv;

    // Legal codes are a contiguous run of ones anchored at the LSB or at the MSB.
    assign q_inv = ~Q;
    assign legal = ((Q & (Q + WIDTH'(1))) == '0) || ((q_inv & (q_inv + WIDTH'(1))) == '0);
    assign err   = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q         <= '0;
            state     <= StIdle;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef JC_ILLEGAL_RECOVER_EN
            err_q     <= 1'b0;
`endif
        end else if (clr) begin
            Q         <= '0;
            state     <= StIdle;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (count_len != '0) begin
                            remaining <= count_len;
                            state     <= StRun;
                            busy      <= 1'b1;
                        end else begin
                            state <= StDone;
                            done  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (stop) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        Q         <= dir ? q_rev : q_fwd;
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                StDone: state <= StIdle;
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
`ifdef JC_ILLEGAL_RECOVER_EN
            // Recovery overrides any step; the FSM and remaining count proceed as normal.
            if (!legal) begin
                Q     <= '0;
                err_q <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        int unsigned pop;
        pop = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pop += 32'(Q[i]);
        end
        if (Q[0] || (Q == '0)) begin
            phase_idx = PW'(pop);
        end else begin
            phase_idx = PW'(2 * WIDTH - pop);
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed self-checking bench for johnson_seq_ctrl (WIDTH=4, CNT_W=8).
module tb_johnson_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       clr;
    logic       start;
    logic       stop;
    logic       dir;
    logic [7:0] count_len;
    logic [3:0] Q;
    logic [2:0] phase_idx;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    johnson_seq_ctrl #(
        .WIDTH(4),
        .CNT_W(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .count_len(count_len),
        .Q        (Q),
        .phase_idx(phase_idx),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [3:0] fwd9 [9] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};

    initial begin
        reset = 1'b0; clr = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0; count_len = '0;
        tick(); tick();
        chk("rst_q", 32'(Q), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_phase", 32'(phase_idx), 32'h0);
        reset = 1'b1;

        // Three forward steps
        start = 1'b1; count_len = 8'd3; dir = 1'b0;
        tick();
        start = 1'b0;
        chk("r3_enter_busy", 32'(busy), 32'h1);
        chk("r3_enter_q", 32'(Q), 32'h0);
        tick(); chk("r3_q1", 32'(Q), 32'h1); chk("r3_busy1", 32'(busy), 32'h1);
        tick(); chk("r3_q2", 32'(Q), 32'h3); chk("r3_busy2", 32'(busy), 32'h1);
        tick(); chk("r3_q3", 32'(Q), 32'h7); chk("r3_busy3", 32'(busy), 32'h0);
        chk("r3_done", 32'(done), 32'h1);
        chk("r3_phase", 32'(phase_idx), 32'h3);
        tick(); chk("r3_done_pulse", 32'(done), 32'h0); chk("r3_hold", 32'(Q), 32'h7);

        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_q", 32'(Q), 32'h0);

        // Nine forward steps with wrap
        start = 1'b1; count_len = 8'd9;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("r9_q%0d", i), 32'(Q), 32'(fwd9[i]));
        end
        chk("r9_done", 32'(done), 32'h1);
        chk("r9_phase", 32'(phase_idx), 32'h1);
        tick();
        clr = 1'b1; tick(); clr = 1'b0;

        // Two reverse steps
        start = 1'b1; count_len = 8'd2; dir = 1'b1;
        tick();
        start = 1'b0;
        tick(); chk("rv_q1", 32'(Q), 32'h8); chk("rv_ph1", 32'(phase_idx), 32'h7);
        tick(); chk("rv_q2", 32'(Q), 32'hC); chk("rv_ph2", 32'(phase_idx), 32'h6);
        chk("rv_done", 32'(done), 32'h1);
        tick();
        clr = 1'b1; tick(); clr = 1'b0;

        // Stop after four steps
        start = 1'b1; count_len = 8'd10; dir = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("st_q4", 32'(Q), 32'hF);
        chk("st_phase", 32'(phase_idx), 32'h4);
        stop = 1'b1;
        tick();
        chk("st_busy", 32'(busy), 32'h0);
        chk("st_done", 32'(done), 32'h0);
        chk("st_q", 32'(Q), 32'hF);
        tick();
        stop = 1'b0;
        chk("st_idle_done", 32'(done), 32'h0);
        chk("st_idle_q", 32'(Q), 32'hF);

        // Zero-length run
        start = 1'b1; count_len = 8'd0;
        tick();
        start = 1'b0;
        chk("z_done", 32'(done), 32'h1);
        chk("z_busy", 32'(busy), 32'h0);
        chk("z_q", 32'(Q), 32'hF);
        tick();
        chk("z_done_end", 32'(done), 32'h0);

        // Asynchronous reset mid-run
        start = 1'b1; count_len = 8'd5;
        tick();
        start = 1'b0;
        tick();
        chk("ar_q_pre", 32'(Q), 32'hE);
        #2 reset = 1'b0;
        #1;
        chk("ar_q", 32'(Q), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_done", 32'(done), 32'h0);
        tick();
        reset = 1'b1;
        tick(); tick(); tick();
        chk("ar_idle_q", 32'(Q), 32'h0);
        chk("ar_idle_busy", 32'(busy), 32'h0);
        chk("ar_idle_done", 32'(done), 32'h0);

`ifdef JC_ILLEGAL_RECOVER_EN
        force dut.Q = 4'b0101;
        #2;
        release dut.Q;
        tick();
        chk("ill_q", 32'(Q), 32'h0);
        chk("ill_err", 32'(err), 32'h1);
        tick();
        chk("ill_err_sticky", 32'(err), 32'h1);
        reset = 1'b0; #1;
        chk("ill_err_rst", 32'(err), 32'h0);
        reset = 1'b1;
`else
        chk("err_tied", 32'(err), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
